// File: rtl/core_mem_pkg.sv
// Shared constants for the core memory arbiter and its helpers.
// Holds the default master count and bus widths, and the master-index width
// derived from the master count.
package core_mem_pkg;

    localparam int unsigned DEF_NUM_MASTERS = 7;
    localparam int unsigned DEF_ADDR_W      = 13;
    localparam int unsigned DEF_DATA_W      = 32;
    localparam int unsigned DEF_BE_W        = DEF_DATA_W / 8;
    localparam int unsigned DEF_IDX_W       = $clog2(DEF_NUM_MASTERS);

    // Index width that stays at least one bit wide when n is 1.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/core_mem_arbiter_if.sv
// Bundle of the Avalon-MM data-master buses of all cores, concatenated per
// master (master i occupies slice i of every packed field).
//   master modport : seen from the cores (drive requests, receive responses)
//   slave modport  : seen from the arbiter (receive requests, drive responses)
interface core_mem_arbiter_if
    import core_mem_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned BE_W        = DEF_BE_W
);

    logic [NUM_MASTERS*ADDR_W-1:0] m_address;
    logic [NUM_MASTERS*BE_W-1:0]   m_byteenable;
    logic [NUM_MASTERS-1:0]        m_read;
    logic [NUM_MASTERS-1:0]        m_write;
    logic [NUM_MASTERS*DATA_W-1:0] m_writedata;
    logic [NUM_MASTERS-1:0]        m_waitrequest;
    logic [DATA_W-1:0]             m_readdata;
    logic [NUM_MASTERS-1:0]        m_readdatavalid;

    modport master (
        output m_address, m_byteenable, m_read, m_write, m_writedata,
        input  m_waitrequest, m_readdata, m_readdatavalid
    );

    modport slave (
        input  m_address, m_byteenable, m_read, m_write, m_writedata,
        output m_waitrequest, m_readdata, m_readdatavalid
    );

endinterface

// File: rtl/core_mem_arbiter_rr_grant.sv
// rr_grant: combinational rotating-priority arbiter.
// Ports:
//   req        in   N      request vector
//   last_grant in   IDX_W  index of the previous winner; search starts above it
//   grant      out  N      one-hot grant (all zero with no request)
//   winner     out  IDX_W  encoded grant index (0 with no request)
//   valid      out  1      some request was granted
module rr_grant
    import core_mem_pkg::*;
#(
    parameter int unsigned N     = DEF_NUM_MASTERS,
    parameter int unsigned IDX_W = DEF_IDX_W
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        cand   = '0;
        grant  = '0;
        winner = '0;
        valid  = 1'b0;
        // k = N wraps back to last_grant itself, so it is checked last.
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IDX_W'((32'(last_grant) + k) % N);
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                winner      = cand;
            end
        end
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: round-robin sharing of one single-port RAM (registered
// address, unregistered data, one-cycle read latency) among NUM_MASTERS cores.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   bus                core-side Avalon-MM bundle (slave modport)
//   mem_address        RAM word address from the winning master
//   mem_byteenable     RAM byte enables from the winning master
//   mem_chipselect     high whenever a transaction is granted
//   mem_write          high when the winner writes (read+write counts as write)
//   mem_writedata      RAM write data from the winning master
//   mem_clken          RAM clock enable, high out of reset
//   mem_readdata       RAM read data, forwarded to all masters
module core_mem_arbiter
    import core_mem_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned BE_W        = DEF_BE_W
) (
    input  logic              clk,
    input  logic              reset_n,
    core_mem_arbiter_if.slave bus,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam int unsigned IDX_W = idx_width(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] grant;
    logic [IDX_W-1:0]       winner;
    logic                   grant_valid;
    logic                   rd_accept;
    logic [NUM_MASTERS-1:0] rdv;

    logic [IDX_W-1:0] last_grant_q;
    logic             rd_pend_valid_q;
    logic [IDX_W-1:0] rd_pend_id_q;

    // Gating with reset_n keeps the RAM port idle and all waitrequests high
    // while reset is held, without needing an extra flop.
    assign req = (bus.m_read | bus.m_write) & {NUM_MASTERS{reset_n}};

    rr_grant #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr_grant (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (grant),
        .winner     (winner),
        .valid      (grant_valid)
    );

    // Read and write together is a write; no read data is returned for it.
    assign rd_accept = grant_valid & bus.m_read[winner] & ~bus.m_write[winner];

    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) begin
                mem_address    = bus.m_address[i*ADDR_W +: ADDR_W];
                mem_byteenable = bus.m_byteenable[i*BE_W +: BE_W];
                mem_writedata  = bus.m_writedata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign mem_chipselect = grant_valid;
    assign mem_write      = grant_valid & bus.m_write[winner];
    assign mem_clken      = reset_n;

    assign bus.m_waitrequest = ~grant;
    assign bus.m_readdata    = mem_readdata;

    always_comb begin
        rdv = '0;
        if (rd_pend_valid_q) begin
            rdv[rd_pend_id_q] = 1'b1;
        end
    end

    assign bus.m_readdatavalid = rdv;

    // Reset value makes master 0 the first candidate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q    <= IDX_W'(NUM_MASTERS - 1);
            rd_pend_valid_q <= 1'b0;
            rd_pend_id_q    <= '0;
        end else begin
            if (grant_valid) begin
                last_grant_q <= winner;
            end
            rd_pend_valid_q <= rd_accept;
            if (rd_accept) begin
                rd_pend_id_q <= winner;
            end
        end
    end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Testbench for core_mem_arbiter: directed transactions push expected grants
// and read responses into queues; a negedge monitor pops and compares them.
module tb_core_mem_arbiter;
    import core_mem_pkg::*;

    localparam int unsigned NM = DEF_NUM_MASTERS;
    localparam int unsigned AW = DEF_ADDR_W;

    typedef struct {
        int          id;
        logic [12:0] addr;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] data;
    } gexp_t;

    typedef struct {
        int          id;
        logic [31:0] data;
    } rexp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    core_mem_arbiter_if bus ();

    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic [31:0] mem_readdata;

    core_mem_arbiter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus            (bus),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata)
    );

    // RAM model: registered address, unregistered data, byte-enabled write.
    logic [31:0] ram [0:8191];
    logic [12:0] ram_aq = '0;
    logic [31:0] ram_tmp;

    initial begin
        for (int a = 0; a < 8192; a++) ram[a] = 32'hC0DE0000 | 32'(a);
    end

    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                ram_tmp = ram[mem_address];
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram_tmp[8*b +: 8] = mem_writedata[8*b +: 8];
                ram[mem_address] <= ram_tmp;
            end
            ram_aq <= mem_address;
        end
    end

    assign mem_readdata = ram[ram_aq];

    int n_tests = 0;
    int n_fail  = 0;
    gexp_t exp_g[$];
    rexp_t exp_r[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    logic [NM-1:0] mon_g;
    logic [NM-1:0] mon_rdv;
    logic          prev_rd = 1'b0;
    int            prev_id = 0;
    int            obs_id;
    gexp_t         ge;
    rexp_t         re;

    always @(negedge clk) begin
        mon_g   = ~bus.m_waitrequest;
        mon_rdv = bus.m_readdatavalid;
        if (mon_rdv != '0) begin
            check("rdv_latency", 32'(mon_rdv), prev_rd ? (32'd1 << prev_id) : 32'd0);
            if (exp_r.size() == 0) begin
                check("unexpected_rdv", 32'(mon_rdv), 32'd0);
            end else begin
                re = exp_r.pop_front();
                check("rdv_id", 32'(mon_rdv), 32'd1 << re.id);
                check("readdata", bus.m_readdata, re.data);
            end
        end
        obs_id = 0;
        for (int i = NM - 1; i >= 0; i--) if (mon_g[i]) obs_id = i;
        if (mon_g != '0) begin
            if (exp_g.size() == 0) begin
                check("unexpected_grant", 32'(mon_g), 32'd0);
            end else begin
                ge = exp_g.pop_front();
                check("grant", 32'(mon_g), 32'd1 << ge.id);
                check("mem_address", 32'(mem_address), 32'(ge.addr));
                check("mem_write", 32'(mem_write), 32'(ge.wr));
                check("mem_chipselect", 32'(mem_chipselect), 32'd1);
                if (ge.wr) begin
                    check("mem_writedata", mem_writedata, ge.data);
                    check("mem_byteenable", 32'(mem_byteenable), 32'(ge.be));
                end
            end
        end
        prev_rd = (mon_g != '0) && bus.m_read[obs_id] && !bus.m_write[obs_id];
        prev_id = obs_id;
    end

    task automatic push_grant(input int id, input logic [12:0] addr, input logic wr,
                              input logic [3:0] be, input logic [31:0] data);
        gexp_t g;
        g.id = id; g.addr = addr; g.wr = wr; g.be = be; g.data = data;
        exp_g.push_back(g);
    endtask

    task automatic push_read(input int id, input logic [31:0] data);
        rexp_t r;
        r.id = id; r.data = data;
        exp_r.push_back(r);
    endtask

    task automatic set_master(input int id, input logic [12:0] addr, input logic [3:0] be,
                              input logic [31:0] wdata);
        bus.m_address[id*AW +: AW]   = addr;
        bus.m_byteenable[id*4 +: 4]  = be;
        bus.m_writedata[id*32 +: 32] = wdata;
    endtask

    // Called at posedge+1; returns at posedge+1 after acceptance.
    task automatic do_op(input int id, input bit rd, input bit wr, input logic [12:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata,
                         input logic [31:0] rdata);
        bit done;
        push_grant(id, addr, wr, be, wdata);
        if (rd && !wr) push_read(id, rdata);
        set_master(id, addr, be, wdata);
        bus.m_read[id]  = rd;
        bus.m_write[id] = wr;
        done = 1'b0;
        for (int c = 0; c < 16 && !done; c++) begin
            @(negedge clk);
            if (!bus.m_waitrequest[id]) done = 1'b1;
        end
        check("op_accepted", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        bus.m_read[id]  = 1'b0;
        bus.m_write[id] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_waitrequest", 32'(bus.m_waitrequest), 32'((1 << NM) - 1));
        check("rst_readdatavalid", 32'(bus.m_readdatavalid), 32'd0);
        check("rst_chipselect", 32'(mem_chipselect), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_clken", 32'(mem_clken), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.m_address    = '0;
        bus.m_byteenable = '0;
        bus.m_read       = '0;
        bus.m_write      = '0;
        bus.m_writedata  = '0;
        reset_n          = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("idle_chipselect", 32'(mem_chipselect), 32'd0);
        check("idle_address", 32'(mem_address), 32'd0);
        check("idle_clken", 32'(mem_clken), 32'd1);
        check("idle_waitrequest", 32'(bus.m_waitrequest), 32'((1 << NM) - 1));
        @(posedge clk);
        #1;

        // Write then read back by master 0.
        do_op(0, 1'b0, 1'b1, 13'h0010, 4'hF, 32'hDEADBEEF, 32'h0);
        do_op(0, 1'b1, 1'b0, 13'h0010, 4'hF, 32'h0, 32'hDEADBEEF);
        idle(2);

        // Partial-byte write by master 3.
        do_op(3, 1'b0, 1'b1, 13'h0020, 4'hF, 32'hDEADBEEF, 32'h0);
        do_op(3, 1'b0, 1'b1, 13'h0020, 4'h3, 32'h12345678, 32'h0);
        do_op(3, 1'b1, 1'b0, 13'h0020, 4'hF, 32'h0, 32'hDEAD5678);
        idle(2);

        // Read and write together at the top address counts as a write.
        do_op(4, 1'b1, 1'b1, 13'h1FFF, 4'hF, 32'hA5A5A5A5, 32'h0);
        idle(2);
        do_op(4, 1'b1, 1'b0, 13'h1FFF, 4'hF, 32'h0, 32'hA5A5A5A5);
        idle(2);

        // Write immediately followed by a read of the same word from another master.
        do_op(6, 1'b0, 1'b1, 13'h0040, 4'hF, 32'h600DF00D, 32'h0);
        do_op(1, 1'b1, 1'b0, 13'h0040, 4'hF, 32'h0, 32'h600DF00D);
        idle(2);

        // All masters hold reads from reset: grants 0..6 then back to 0.
        reset_n = 1'b0;
        for (int i = 0; i < int'(NM); i++) begin
            set_master(i, 13'h0100 + 13'(i), 4'hF, 32'h0);
            bus.m_read[i] = 1'b1;
        end
        for (int k = 0; k < 8; k++) begin
            push_grant(k % 7, 13'h0100 + 13'(k % 7), 1'b0, 4'hF, 32'h0);
            push_read(k % 7, 32'hC0DE0100 + 32'(k % 7));
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1 bus.m_read = '0;
        idle(3);

        // Masters 2 and 5 read continuously; reset lands right after a grant.
        set_master(2, 13'h0202, 4'hF, 32'h0);
        set_master(5, 13'h0205, 4'hF, 32'h0);
        push_grant(2, 13'h0202, 1'b0, 4'hF, 32'h0);
        bus.m_read[2] = 1'b1;
        bus.m_read[5] = 1'b1;
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        @(negedge clk);
        check("rst2_readdatavalid", 32'(bus.m_readdatavalid), 32'd0);
        push_grant(2, 13'h0202, 1'b0, 4'hF, 32'h0);
        push_read(2, 32'hC0DE0202);
        push_grant(5, 13'h0205, 1'b0, 4'hF, 32'h0);
        push_read(5, 32'hC0DE0205);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus.m_read = '0;
        idle(3);

        check("grants_left", 32'(exp_g.size()), 32'd0);
        check("reads_left", 32'(exp_r.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
